// File: rtl/floor_request_encoder.sv
// Purpose: latches floor calls and runs a SCAN elevator policy with a door-dwell timer.
// Latency: a call is visible on pending one cycle later; commands are Moore outputs of the registered state.
// Backpressure: none; calls are always accepted, except a call to the current floor while the door is open.
module floor_request_encoder #(
    parameter int FLOOR_W     = 3,
    parameter int FLOORS      = 8,
    parameter int DOOR_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  call_in,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic               arrive,
    output logic [FLOORS-1:0]  pending,
    output logic [FLOOR_W-1:0] target_floor,
    output logic               target_valid,
    output logic               move_up,
    output logic               move_down,
    output logic               door_open
);

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DOOR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               dir_up;
    logic               dir_up_nxt;
    logic [CNT_W-1:0]   door_cnt;
    logic [CNT_W-1:0]   door_cnt_nxt;

    logic               above;
    logic               below;
    logic               here;
    logic [FLOOR_W-1:0] up_tgt;
    logic [FLOOR_W-1:0] dn_tgt;
    logic [FLOORS-1:0]  here_mask;
    logic [FLOORS-1:0]  call_acc;
    logic [FLOORS-1:0]  clear_mask;
    logic               door_entry;

    assign here_mask = FLOORS'(1) << cur_floor;
    assign here      = |(pending & here_mask);

    // Scan pending for requests above/below the car; nearest one in each direction becomes the target.
    always_comb begin
        above  = 1'b0;
        below  = 1'b0;
        up_tgt = '0;
        dn_tgt = '0;
        // Descending scan: last hit is the lowest floor above the car.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                above  = 1'b1;
                up_tgt = FLOOR_W'(i);
            end
        end
        // Ascending scan: last hit is the highest floor below the car.
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                below  = 1'b1;
                dn_tgt = FLOOR_W'(i);
            end
        end
    end

    // SCAN next-state: stop on arrival at a requested floor, otherwise keep heading while work remains that way.
    always_comb begin
        state_nxt    = state;
        dir_up_nxt   = dir_up;
        door_cnt_nxt = door_cnt;
        case (state)
            S_IDLE: begin
                // Upward preference when requests exist on both sides.
                if (here) begin
                    state_nxt = S_DOOR;
                end else if (above) begin
                    state_nxt = S_UP;
                end else if (below) begin
                    state_nxt = S_DOWN;
                end
            end
            S_UP: begin
                if (arrive && here) begin
                    state_nxt  = S_DOOR;
                    dir_up_nxt = 1'b1;
                end else if (!above) begin
                    state_nxt = below ? S_DOWN : S_IDLE;
                end
            end
            S_DOWN: begin
                if (arrive && here) begin
                    state_nxt  = S_DOOR;
                    dir_up_nxt = 1'b0;
                end else if (!below) begin
                    state_nxt = above ? S_UP : S_IDLE;
                end
            end
            S_DOOR: begin
                if (door_cnt == '0) begin
                    if (dir_up) begin
                        state_nxt = above ? S_UP : (below ? S_DOWN : S_IDLE);
                    end else begin
                        state_nxt = below ? S_DOWN : (above ? S_UP : S_IDLE);
                    end
                end else begin
                    door_cnt_nxt = door_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if ((state_nxt == S_DOOR) && (state != S_DOOR)) begin
            door_cnt_nxt = DOOR_LOAD;
        end
    end

    // Request latch inputs: the served floor is cleared on door entry and ignored while the door is open.
    always_comb begin
        door_entry = (state_nxt == S_DOOR) && (state != S_DOOR);
        call_acc   = call_in;
        if (state == S_DOOR) begin
            call_acc = call_in & ~here_mask;
        end
        clear_mask = door_entry ? here_mask : '0;
    end

    // State, direction, dwell counter and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            dir_up   <= 1'b1;
            door_cnt <= '0;
            pending  <= '0;
        end else begin
            state    <= state_nxt;
            dir_up   <= dir_up_nxt;
            door_cnt <= door_cnt_nxt;
            pending  <= (pending | call_acc) & ~clear_mask;
        end
    end

    // Moore command decode; target only meaningful while moving toward an existing request.
    always_comb begin
        move_up      = (state == S_UP);
        move_down    = (state == S_DOWN);
        door_open    = (state == S_DOOR);
        target_floor = '0;
        target_valid = 1'b0;
        if ((state == S_UP) && above) begin
            target_floor = up_tgt;
            target_valid = 1'b1;
        end else if ((state == S_DOWN) && below) begin
            target_floor = dn_tgt;
            target_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_floor_request_encoder.sv
// Purpose: directed and random checking of floor_request_encoder against a behavioural SCAN model.
// Latency: inputs change 2 time units after the rising edge; outputs compared on the falling edge.
// Backpressure: not applicable.
module tb_floor_request_encoder;

    localparam int FW = 3;
    localparam int NF = 8;
    localparam int DC = 4;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NF-1:0] call_in = '0;
    logic [FW-1:0] cur_floor = '0;
    logic          arrive = 1'b0;
    logic [NF-1:0] pending;
    logic [FW-1:0] target_floor;
    logic          target_valid;
    logic          move_up;
    logic          move_down;
    logic          door_open;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    floor_request_encoder #(
        .FLOOR_W    (FW),
        .FLOORS     (NF),
        .DOOR_CYCLES(DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .call_in     (call_in),
        .cur_floor   (cur_floor),
        .arrive      (arrive),
        .pending     (pending),
        .target_floor(target_floor),
        .target_valid(target_valid),
        .move_up     (move_up),
        .move_down   (move_down),
        .door_open   (door_open)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit [NF-1:0] m_pend    = '0;
    int          m_mode    = M_IDLE;
    bit          m_dir_up  = 1'b1;
    int          m_door_left = 0;   // door_open cycles still to show, including the current one
    int          mc;
    bit          ma, mb, mh;
    int          nm;
    bit [NF-1:0] np;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend      = '0;
            m_mode      = M_IDLE;
            m_dir_up    = 1'b1;
            m_door_left = 0;
        end else begin
            mc = int'(cur_floor);
            ma = 1'b0;
            mb = 1'b0;
            for (int i = 0; i < NF; i++) begin
                if (m_pend[i] && i > mc) ma = 1'b1;
                if (m_pend[i] && i < mc) mb = 1'b1;
            end
            mh = m_pend[mc];
            nm = m_mode;
            case (m_mode)
                M_IDLE: nm = mh ? M_DOOR : (ma ? M_UP : (mb ? M_DOWN : M_IDLE));
                M_UP: begin
                    if (arrive && mh) begin nm = M_DOOR; m_dir_up = 1'b1; end
                    else if (!ma) nm = mb ? M_DOWN : M_IDLE;
                end
                M_DOWN: begin
                    if (arrive && mh) begin nm = M_DOOR; m_dir_up = 1'b0; end
                    else if (!mb) nm = ma ? M_UP : M_IDLE;
                end
                default: begin
                    if (m_door_left == 1) begin
                        if (m_dir_up) nm = ma ? M_UP : (mb ? M_DOWN : M_IDLE);
                        else          nm = mb ? M_DOWN : (ma ? M_UP : M_IDLE);
                    end else begin
                        m_door_left--;
                    end
                end
            endcase
            np = m_pend;
            for (int i = 0; i < NF; i++) begin
                if (call_in[i] && !(m_mode == M_DOOR && i == mc)) np[i] = 1'b1;
            end
            if (nm == M_DOOR && m_mode != M_DOOR) begin
                np[mc]      = 1'b0;
                m_door_left = DC;
            end
            m_pend = np;
            m_mode = nm;
        end
    end

    // Single compare process: every falling edge, DUT outputs against the model.
    logic [FW-1:0] e_tgt;
    logic          e_vld;
    always @(negedge clk) begin
        e_tgt = '0;
        e_vld = 1'b0;
        if (m_mode == M_UP) begin
            for (int i = NF - 1; i > int'(cur_floor); i--)
                if (m_pend[i]) begin e_tgt = FW'(i); e_vld = 1'b1; end
        end else if (m_mode == M_DOWN) begin
            for (int i = 0; i < int'(cur_floor); i++)
                if (m_pend[i]) begin e_tgt = FW'(i); e_vld = 1'b1; end
        end
        check("cycle", {pending, target_floor, target_valid, move_up, move_down, door_open},
              {m_pend, e_tgt, e_vld, m_mode == M_UP, m_mode == M_DOWN, m_mode == M_DOOR});
        check("exclusive", {move_up & move_down, door_open & (move_up | move_down)}, 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step_floor(input int f);
        cur_floor = FW'(f);
        arrive    = 1'b1;
        tick();
        arrive    = 1'b0;
    endtask

    task automatic drive_to(input int dest);
        int guard = 0;
        while (int'(cur_floor) != dest && guard < NF) begin
            step_floor((int'(cur_floor) < dest) ? int'(cur_floor) + 1 : int'(cur_floor) - 1);
            guard++;
        end
    endtask

    // Counts door_open cycles from now; bounded so a stuck door cannot hang the run.
    task automatic wait_door(output int n);
        int guard = 0;
        n = 0;
        while (!door_open && guard < 20) begin tick(); guard++; end
        while (door_open && n < 50) begin n++; tick(); end
    endtask

    task automatic check_idle(input string name);
        check(name, {pending, move_up, move_down, door_open, target_valid}, 0);
    endtask

    int n;
    int car_pos;
    int guard;

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        check_idle("reset_state");
        check("reset_target", target_floor, 0);
        reset = 1'b0;
        tick();

        // Reset in the middle of a door dwell with requests 0 and 7 outstanding.
        cur_floor = 3'd3;
        call_in   = 8'h08;
        tick();
        check("t1_latch", pending, 8'h08);
        call_in = 8'h00;
        tick();
        check("t1_door", {door_open, pending}, {1'b1, 8'h00});
        call_in = 8'h81;
        tick();
        check("t1_pend81", {door_open, pending}, {1'b1, 8'h81});
        call_in = 8'h00;
        #1 reset = 1'b1;
        #1 check_idle("t1_reset_now");
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check_idle("t1_after_release");

        // Single call to floor 5 from floor 0; intermediate arrivals must not stop the car.
        cur_floor = 3'd0;
        call_in   = 8'h20;
        tick();
        check("t2_latch", {pending, move_up}, {8'h20, 1'b0});
        call_in = 8'h00;
        tick();
        check("t2_move", {move_up, target_floor, target_valid}, {1'b1, 3'd5, 1'b1});
        for (int f = 1; f <= 4; f++) begin
            step_floor(f);
            check("t2_pass", {door_open, move_up}, {1'b0, 1'b1});
        end
        step_floor(5);
        check("t2_stop", {door_open, pending}, {1'b1, 8'h00});
        wait_door(n);
        check("t2_door_len", n, 4);
        check_idle("t2_idle");

        // Requests at 0 and 6 from floor 3: up first, then reverse.
        cur_floor = 3'd3;
        call_in   = 8'h41;
        tick();
        call_in = 8'h00;
        tick();
        check("t3_up", {move_up, target_floor, target_valid}, {1'b1, 3'd6, 1'b1});
        drive_to(6);
        wait_door(n);
        check("t3_door6_len", n, 4);
        check("t3_down", {move_down, target_floor, target_valid, pending}, {1'b1, 3'd0, 1'b1, 8'h01});
        drive_to(0);
        wait_door(n);
        check("t3_door0_len", n, 4);
        check_idle("t3_idle");

        // Call at the current floor; repeat call during the dwell is not latched.
        cur_floor = 3'd2;
        call_in   = 8'h04;
        tick();
        check("t4_wait", {door_open, pending}, {1'b0, 8'h04});
        call_in = 8'h00;
        tick();
        check("t4_door", door_open, 1'b1);
        call_in = 8'h04;
        tick();
        check("t4_mask_a", pending, 8'h00);
        tick();
        check("t4_mask_b", pending, 8'h00);
        call_in = 8'h00;
        wait_door(n);
        check_idle("t4_idle");

        // Arrival with a stop and a new call in the same cycle.
        cur_floor = 3'd3;
        call_in   = 8'h90;
        tick();
        call_in = 8'h00;
        tick();
        check("t5_up", {move_up, target_floor}, {1'b1, 3'd4});
        cur_floor = 3'd4;
        arrive    = 1'b1;
        call_in   = 8'h02;
        tick();
        arrive  = 1'b0;
        call_in = 8'h00;
        check("t5_both", {door_open, pending}, {1'b1, 8'h82});
        wait_door(n);
        check("t5_continue", {move_up, target_floor, target_valid}, {1'b1, 3'd7, 1'b1});
        drive_to(7);
        wait_door(n);
        check("t5_reverse", {move_down, target_floor, target_valid}, {1'b1, 3'd1, 1'b1});
        drive_to(1);
        wait_door(n);
        check_idle("t5_idle");

        // Random calls with car motion that follows the commands.
        car_pos = int'(cur_floor);
        for (int c = 0; c < 10000; c++) begin
            call_in = ($urandom_range(0, 5) == 0) ? NF'(1) << $urandom_range(0, NF - 1) : '0;
            arrive  = 1'b0;
            if (move_up && car_pos < NF - 1 && $urandom_range(0, 2) == 0) begin
                car_pos++;
                arrive = 1'b1;
            end else if (move_down && car_pos > 0 && $urandom_range(0, 2) == 0) begin
                car_pos--;
                arrive = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                arrive = 1'b1;
            end
            cur_floor = FW'(car_pos);
            tick();
        end

        // Drain: with no new calls every request must be served.
        call_in = '0;
        guard   = 0;
        while (!(pending == '0 && !move_up && !move_down && !door_open) && guard < 3000) begin
            arrive = 1'b0;
            if (move_up && car_pos < NF - 1) begin car_pos++; arrive = 1'b1; end
            else if (move_down && car_pos > 0) begin car_pos--; arrive = 1'b1; end
            cur_floor = FW'(car_pos);
            tick();
            guard++;
        end
        arrive = 1'b0;
        check_idle("drain_all_served");

        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/floor_request_encoder.md
Name: floor_request_encoder

Overview:
- Sequential counterpart to the floor decoders: turns latched multi-hot floor call buttons back into a binary target floor and a travel direction.
- Uses a SCAN policy with a door-dwell timer.
- Sits between the call-button inputs and the car motion datapath. The datapath reports the current floor and arrival strobes; this block issues move/door commands.

Parameters:
- FLOOR_W, 3, width of floor index.
- FLOORS, 8, number of floors. Must equal 2**FLOOR_W.
- DOOR_CYCLES, 4, cycles door_open stays high per stop. Must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- call_in  input  FLOORS  call button pulses, one bit per floor. Multi-hot allowed.
- cur_floor  input  FLOOR_W  binary floor the car is at or passing.
- arrive  input  1  one-cycle strobe: car has reached cur_floor.
- pending  output  FLOORS  latched outstanding requests.
- target_floor  output  FLOOR_W  binary-encoded next stop.
- target_valid  output  1  target_floor meaningful.
- move_up  output  1  command car upward.
- move_down  output  1  command car downward.
- door_open  output  1  door open command.

Behaviour:
- Reset (async, immediate) clears:
  - pending=0, state=IDLE, saved direction=UP, door counter=0.
  - All outputs 0, including target_floor=0 and target_valid=0.
  - Applies mid-move or mid-door; no request survives.
- Request latch:
  - pending <= (pending | call_in) & ~clear_mask each cycle.
  - A call at cycle n is visible on pending at n+1.
  - clear_mask is one-hot of cur_floor on the cycle the FSM enters DOOR; otherwise 0.
  - While in DOOR, call_in[cur_floor] is masked (not latched). Calls to other floors latch normally.
- Helper terms, combinational from registered pending and cur_floor:
  - above = any pending bit with index > cur_floor.
  - below = any pending bit with index < cur_floor.
  - here = pending[cur_floor].
- FSM states: IDLE, UP, DOWN, DOOR.
- IDLE:
  - here -> DOOR.
  - else above -> UP.
  - else below -> DOWN.
  - else stay.
  - arrive is ignored.
- UP:
  - arrive & here -> DOOR; saved direction = UP.
  - else if !above: below -> DOWN, else -> IDLE.
  - else stay.
- DOWN: mirror of UP, with saved direction = DOWN.
- DOOR:
  - Counter loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - When counter is 0, leave DOOR. Priority: continue in saved direction if requests remain that way, else reverse if requests exist the other way, else IDLE.
  - arrive is ignored.
  - door_open is high for exactly DOOR_CYCLES cycles per stop.
- Outputs (Moore, decoded from registered state; target from registered pending):
  - move_up = (state==UP); move_down = (state==DOWN); door_open = (state==DOOR).
  - target_floor in UP: lowest pending index > cur_floor. In DOWN: highest pending index < cur_floor.
  - target_valid = 1 in UP/DOWN when such an index exists; else target_valid=0 and target_floor=0.
  - move_up and move_down are never both high.
- Stops: the car stops at any pending floor it arrives at, regardless of where the call came from.
- Arithmetic: all floor comparisons are unsigned, FLOOR_W bits. There is no wrap-around: top and bottom floors are terminal.
- Simultaneous events:
  - arrive with here plus a new call elsewhere: both take effect; the cur_floor bit is cleared and the other bit is set.
  - In IDLE with requests both above and below, and none here: UP wins.

Test Plan:
- Reset mid-DOOR with pending=8'h81: assert reset -> pending=0, all outputs 0 immediately; after release, state stays IDLE with no calls.
- cur_floor=0, IDLE, call_in=8'h20 for 1 cycle:
  - pending=8'h20 next cycle, then move_up=1, target_floor=5, target_valid=1.
  - arrive pulses at floors 1-4 are ignored (no stop).
  - arrive at floor 5 -> door_open=1 for exactly 4 cycles, pending=0, then IDLE.
- cur_floor=3, pending=8'h41 (floors 0 and 6), IDLE:
  - move_up, target 6; stop at 6.
  - After the door, reverse: move_down, target 0; stop at 0; then IDLE.
- Call at cur_floor=2 while in IDLE -> door_open two cycles after the call; a repeat call_in=8'h04 during DOOR does not set pending[2].
- Moving UP at cur_floor=4, pending=8'h90: arrive with here=1 in the same cycle as call_in=8'h02 -> pending becomes 8'h82 and the FSM enters DOOR; on exit it continues UP to floor 7, then goes DOWN to floor 1.
- Stress: random call_in and arrive for 10k cycles, with the arrive model consistent with the motion commands -> move_up & move_down never both high; every pending bit is eventually cleared; door_open is never high while moving.
